// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: two request/response channels
// plus the shared response data.
interface alu_arbiter_if;
    logic        a_req_valid;
    logic        a_req_ready;
    logic [3:0]  a_req_op;
    logic [31:0] a_req_op1;
    logic [31:0] a_req_op2;
    logic        a_rsp_valid;
    logic        a_rsp_ready;

    logic        b_req_valid;
    logic        b_req_ready;
    logic [3:0]  b_req_op;
    logic [31:0] b_req_op1;
    logic [31:0] b_req_op2;
    logic        b_rsp_valid;
    logic        b_rsp_ready;

    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    modport master (
        output a_req_valid, a_req_op, a_req_op1, a_req_op2, a_rsp_ready,
        output b_req_valid, b_req_op, b_req_op1, b_req_op2, b_rsp_ready,
        input  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        input  rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  a_req_valid, a_req_op, a_req_op1, a_req_op2, a_rsp_ready,
        input  b_req_valid, b_req_op, b_req_op1, b_req_op2, b_rsp_ready,
        output a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        output rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with
// registered ALU drive, registered response capture and a completion counter.
module alu_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [3:0]       alu_op,
    output logic [31:0]      op1,
    output logic [31:0]      op2,
    input  logic [31:0]      result,
    input  logic             zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic {GNT_A, GNT_B} grant_t;

    state_t      state, state_nxt;
    grant_t      gnt, last_grant, win;
    logic        accept, rsp_fire, err_q;
    logic [3:0]  sel_op;
    logic [31:0] sel_op1, sel_op2;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q, rsp_err_q;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1101: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_nxt       = state;
        win             = GNT_A;
        accept          = 1'b0;
        rsp_fire        = 1'b0;
        bus.a_req_ready = 1'b0;
        bus.b_req_ready = 1'b0;
        bus.a_rsp_valid = 1'b0;
        bus.b_rsp_valid = 1'b0;

        // A wins unless only B is requesting, or both are and A won last time
        if (!bus.a_req_valid || (bus.b_req_valid && last_grant == GNT_A))
            win = GNT_B;

        case (state)
            IDLE: begin
                if (rst_n && (bus.a_req_valid || bus.b_req_valid)) begin
                    accept          = 1'b1;
                    bus.a_req_ready = (win == GNT_A);
                    bus.b_req_ready = (win == GNT_B);
                    state_nxt       = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                bus.a_rsp_valid = (gnt == GNT_A);
                bus.b_rsp_valid = (gnt == GNT_B);
                rsp_fire = (gnt == GNT_A) ? bus.a_rsp_ready : bus.b_rsp_ready;
                if (rsp_fire)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_op  = (win == GNT_A) ? bus.a_req_op  : bus.b_req_op;
        sel_op1 = (win == GNT_A) ? bus.a_req_op1 : bus.b_req_op1;
        sel_op2 = (win == GNT_A) ? bus.a_req_op2 : bus.b_req_op2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= GNT_A;
            last_grant   <= GNT_B;
            alu_op       <= '0;
            op1          <= '0;
            op2          <= '0;
            err_q        <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt    <= win;
                alu_op <= sel_op;
                op1    <= sel_op1;
                op2    <= sel_op2;
                err_q  <= !op_legal(sel_op);
            end
            // Illegal opcodes still load the drive registers; the ALU output is discarded here
            if (state == EXEC) begin
                rsp_result_q <= err_q ? '0 : result;
                rsp_zero_q   <= err_q ? 1'b1 : zero;
                rsp_err_q    <= err_q;
            end
            if (rsp_fire) begin
                last_grant <= gnt;
                op_count   <= op_count + 1'b1;
            end
        end
    end

    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop and each
// scenario task checks handshakes, captured results and the counter.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if bus();
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, alu_res;
    logic        alu_zero, busy;
    logic [15:0] op_count;

    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_op(alu_op), .op1(op1), .op2(op2),
        .result(alu_res), .zero(alu_zero),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter_if wbus();
    logic [3:0]  w_alu_op;
    logic [31:0] w_op1, w_op2, w_res;
    logic        w_zero, w_busy;
    logic [1:0]  w_count;

    alu_arbiter #(.CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus.slave),
        .alu_op(w_alu_op), .op1(w_op1), .op2(w_op2),
        .result(w_res), .zero(w_zero),
        .busy(w_busy), .op_count(w_count)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            4'b0000: alu_model = x & y;
            4'b0001: alu_model = x | y;
            4'b0010: alu_model = x + y;
            4'b0110: alu_model = x - y;
            4'b0111: alu_model = {31'b0, $signed(x) < $signed(y)};
            4'b1000: alu_model = x >> y[4:0];
            4'b1001: alu_model = x << y[4:0];
            4'b1010: alu_model = $unsigned($signed(x) >>> y[4:0]);
            4'b1101: alu_model = x ^ y;
            default: alu_model = 32'hDEADBEEF;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_model(alu_op, op1, op2);
        alu_zero = (alu_res == '0);
        w_res    = alu_model(w_alu_op, w_op1, w_op2);
        w_zero   = (w_res == '0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic init_inputs();
        bus.a_req_valid = 0; bus.a_req_op = '0; bus.a_req_op1 = '0; bus.a_req_op2 = '0; bus.a_rsp_ready = 0;
        bus.b_req_valid = 0; bus.b_req_op = '0; bus.b_req_op1 = '0; bus.b_req_op2 = '0; bus.b_rsp_ready = 0;
        wbus.a_req_valid = 0; wbus.a_req_op = '0; wbus.a_req_op1 = '0; wbus.a_req_op2 = '0; wbus.a_rsp_ready = 0;
        wbus.b_req_valid = 0; wbus.b_req_op = '0; wbus.b_req_op1 = '0; wbus.b_req_op2 = '0; wbus.b_rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick(); #1;
        checks++;
        if ({bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid, busy});
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== 34'h0) begin
            errors++; $display("FAIL reset_rsp got %h want 0", {bus.rsp_result, bus.rsp_zero, bus.rsp_err});
        end
        checks++;
        if ({alu_op, op1, op2} !== 68'h0 || op_count !== 16'd0 || w_count !== 2'd0) begin
            errors++; $display("FAIL reset_drive got %h/%0d/%0d want 0/0/0", {alu_op, op1, op2}, op_count, w_count);
        end
        tick(); rst_n = 1;
        tick();
    endtask

    task automatic test_tie_alternate();
        logic win_a;
        bus.a_req_valid = 1; bus.a_req_op = 4'b0110; bus.a_req_op1 = 32'd5; bus.a_req_op2 = 32'd5;
        bus.b_req_valid = 1; bus.b_req_op = 4'b1010; bus.b_req_op1 = 32'hFFFF0000; bus.b_req_op2 = 32'd5;
        bus.a_rsp_ready = 1; bus.b_rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            win_a = (k % 2 == 0);
            #1;
            checks++;
            if (bus.a_req_ready !== win_a || bus.b_req_ready !== !win_a) begin
                errors++; $display("FAIL tie_grant%0d got a=%b b=%b want a=%b", k, bus.a_req_ready, bus.b_req_ready, win_a);
            end
            tick(); #1;
            checks++;
            if (bus.a_req_ready !== 1'b0 || bus.b_req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL tie_exec_ready%0d got a=%b b=%b busy=%b want 0 0 1", k, bus.a_req_ready, bus.b_req_ready, busy);
            end
            tick(); #1;
            checks++;
            if (bus.a_rsp_valid !== win_a || bus.b_rsp_valid !== !win_a) begin
                errors++; $display("FAIL tie_rsp_valid%0d got a=%b b=%b want a=%b", k, bus.a_rsp_valid, bus.b_rsp_valid, win_a);
            end
            checks++;
            if (win_a ? (bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b1)
                      : (bus.rsp_result !== 32'hFFFFF800 || bus.rsp_zero !== 1'b0)) begin
                errors++; $display("FAIL tie_result%0d got %h z=%b want %h", k, bus.rsp_result, bus.rsp_zero, win_a ? 32'h0 : 32'hFFFFF800);
            end
            checks++;
            if (op_count !== 16'(k)) begin
                errors++; $display("FAIL tie_count_pre%0d got %0d want %0d", k, op_count, k);
            end
            tick();
        end
        #1;
        checks++;
        if (op_count !== 16'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL tie_count got %0d busy=%b want 4 0", op_count, busy);
        end
        bus.a_req_valid = 0; bus.b_req_valid = 0;
        bus.a_rsp_ready = 0; bus.b_rsp_ready = 0;
        tick();
    endtask

    task automatic test_single_a();
        bus.a_req_valid = 1; bus.a_req_op = 4'b0010; bus.a_req_op1 = 32'h7FFFFFFF; bus.a_req_op2 = 32'h00000001;
        #1;
        checks++;
        if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got a=%b b=%b want 1 0", bus.a_req_ready, bus.b_req_ready);
        end
        tick(); bus.a_req_valid = 0; #1;
        checks++;
        if (alu_op !== 4'b0010 || op1 !== 32'h7FFFFFFF || op2 !== 32'h1 || bus.a_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drive got %h %h %h v=%b want 2 7fffffff 1 0", alu_op, op1, op2, bus.a_rsp_valid);
        end
        tick(); #1;
        checks++;
        if (bus.a_rsp_valid !== 1'b1 || bus.rsp_result !== 32'h80000000 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v=%b %h z=%b e=%b want 1 80000000 0 0", bus.a_rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err);
        end
        bus.a_rsp_ready = 1;
        tick(); bus.a_rsp_ready = 0; #1;
        checks++;
        if (op_count !== 16'd5 || bus.a_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_count got %0d v=%b busy=%b want 5 0 0", op_count, bus.a_rsp_valid, busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.b_req_valid = 1; bus.b_req_op = 4'b0111; bus.b_req_op1 = 32'hFFFFFFFF; bus.b_req_op2 = 32'h7FFFFFFF;
        #1;
        checks++;
        if (bus.b_req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_b_ready got %b want 1", bus.b_req_ready);
        end
        tick();
        bus.b_req_valid = 0;
        bus.a_req_valid = 1; bus.a_req_op = 4'b0000; bus.a_req_op1 = 32'hF0F0F0F0; bus.a_req_op2 = 32'h0FF00FF0;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.b_rsp_valid !== 1'b1 || bus.rsp_result !== 32'h1 || bus.a_req_ready !== 1'b0 ||
                op_count !== 16'd5 || alu_op !== 4'b0111) begin
                errors++; $display("FAIL bp_hold%0d got v=%b %h ar=%b cnt=%0d op=%h want 1 00000001 0 5 7",
                                   k, bus.b_rsp_valid, bus.rsp_result, bus.a_req_ready, op_count, alu_op);
            end
            tick();
        end
        bus.b_rsp_ready = 1;
        tick(); bus.b_rsp_ready = 0; #1;
        checks++;
        if (op_count !== 16'd6 || bus.a_req_ready !== 1'b1 || bus.b_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got cnt=%0d ar=%b bv=%b want 6 1 0", op_count, bus.a_req_ready, bus.b_rsp_valid);
        end
        tick(); bus.a_req_valid = 0;
        tick(); #1;
        checks++;
        if (bus.a_rsp_valid !== 1'b1 || bus.rsp_result !== 32'h00F000F0) begin
            errors++; $display("FAIL bp_a_result got v=%b %h want 1 00f000f0", bus.a_rsp_valid, bus.rsp_result);
        end
        bus.a_rsp_ready = 1;
        tick(); bus.a_rsp_ready = 0;
        tick();
    endtask

    task automatic test_illegal();
        bus.a_req_valid = 1; bus.a_req_op = 4'b0011; bus.a_req_op1 = 32'h12345678; bus.a_req_op2 = 32'h1;
        tick(); bus.a_req_valid = 0; #1;
        checks++;
        if (alu_op !== 4'b0011 || op1 !== 32'h12345678) begin
            errors++; $display("FAIL illegal_drive got %h %h want 3 12345678", alu_op, op1);
        end
        tick(); #1;
        checks++;
        if (bus.a_rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b1) begin
            errors++; $display("FAIL illegal_rsp got v=%b e=%b %h z=%b want 1 1 0 1", bus.a_rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_zero);
        end
        bus.a_rsp_ready = 1;
        tick(); bus.a_rsp_ready = 0;
        bus.a_req_valid = 1; bus.a_req_op = 4'b0001;
        bus.b_req_valid = 1; bus.b_req_op = 4'b1101; bus.b_req_op1 = 32'hFF00FF00; bus.b_req_op2 = 32'h0F0F0F0F;
        #1;
        checks++;
        if (bus.b_req_ready !== 1'b1 || bus.a_req_ready !== 1'b0 || op_count !== 16'd8) begin
            errors++; $display("FAIL illegal_next_grant got b=%b a=%b cnt=%0d want 1 0 8", bus.b_req_ready, bus.a_req_ready, op_count);
        end
        tick(); bus.a_req_valid = 0; bus.b_req_valid = 0;
        tick(); #1;
        checks++;
        if (bus.b_rsp_valid !== 1'b1 || bus.rsp_result !== 32'hF00FF00F || bus.rsp_err !== 1'b0 || bus.rsp_zero !== 1'b0) begin
            errors++; $display("FAIL illegal_b_rsp got v=%b %h e=%b z=%b want 1 f00ff00f 0 0", bus.b_rsp_valid, bus.rsp_result, bus.rsp_err, bus.rsp_zero);
        end
        bus.b_rsp_ready = 1;
        tick(); bus.b_rsp_ready = 0; #1;
        checks++;
        if (op_count !== 16'd9) begin
            errors++; $display("FAIL illegal_count got %0d want 9", op_count);
        end
        tick();
    endtask

    task automatic test_reset_in_resp();
        bus.a_req_valid = 1; bus.a_req_op = 4'b0001; bus.a_req_op1 = 32'h1; bus.a_req_op2 = 32'h2;
        tick();
        bus.b_req_valid = 1; bus.b_req_op = 4'b0010;
        tick(); #1;
        checks++;
        if (bus.a_rsp_valid !== 1'b1 || bus.rsp_result !== 32'h3) begin
            errors++; $display("FAIL rir_pre got v=%b %h want 1 00000003", bus.a_rsp_valid, bus.rsp_result);
        end
        rst_n = 0; #1;
        checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.a_req_ready, bus.b_req_ready, busy} !== 5'b0 ||
            bus.rsp_result !== 32'h0 || {alu_op, op1, op2} !== 68'h0 || op_count !== 16'd0) begin
            errors++; $display("FAIL rir_async got flags=%b %h drive=%h cnt=%0d want 0 0 0 0",
                               {bus.a_rsp_valid, bus.b_rsp_valid, bus.a_req_ready, bus.b_req_ready, busy},
                               bus.rsp_result, {alu_op, op1, op2}, op_count);
        end
        tick(); tick(); rst_n = 1; #1;
        checks++;
        if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b0 || bus.a_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rir_tie got a=%b b=%b av=%b want 1 0 0", bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid);
        end
        bus.a_req_valid = 0; bus.b_req_valid = 0;
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt;
        wbus.a_req_valid = 1; wbus.a_req_op = 4'b0010; wbus.a_req_op1 = 32'd1; wbus.a_req_op2 = 32'd2;
        wbus.a_rsp_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick(); tick(); tick(); #1;
            exp_cnt = 2'((k + 1) % 4);
            checks++;
            if (w_count !== exp_cnt) begin
                errors++; $display("FAIL wrap_count%0d got %0d want %0d", k, w_count, exp_cnt);
            end
        end
        wbus.a_req_valid = 0; wbus.a_rsp_ready = 0;
        tick();
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_tie_alternate();
        test_single_a();
        test_backpressure();
        test_illegal();
        test_reset_in_resp();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
